// File: rtl/multi_cycle_ctrl_if.sv
// rtl/multi_cycle_ctrl_if.sv - IR/flag inputs and datapath control outputs of the multi-cycle controller
interface multi_cycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic       ir_we;
  logic       iord;
  logic       mem_rd;
  logic       mem_wr;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_we;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic       retire;
  logic [3:0] state;
  logic       illegal;
  logic       mem_err;

  modport master (
    input  op, func, zero, mem_ready,
    output pc_we, ir_we, iord, mem_rd, mem_wr, reg_dst, mem_to_reg, reg_we,
           alu_src_a, alu_src_b, alu_op, pc_src, retire, state, illegal, mem_err
  );

  modport slave (
    output op, func, zero, mem_ready,
    input  pc_we, ir_we, iord, mem_rd, mem_wr, reg_dst, mem_to_reg, reg_we,
           alu_src_a, alu_src_b, alu_op, pc_src, retire, state, illegal, mem_err
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle MIPS-subset control FSM with memory-wait timeout and illegal-opcode trap
module multi_cycle_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  multi_cycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3,
    S_MEM_RD = 4'd4, S_MEM_WB = 4'd5, S_MEM_WR = 4'd6, S_R_EX = 4'd7,
    S_SH_EX = 4'd8, S_R_WB = 4'd9, S_I_EX = 4'd10, S_I_WB = 4'd11,
    S_BR = 4'd12, S_JMP = 4'd13, S_TRAP = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_q, illegal_d;
  logic              mem_err_q, mem_err_d;

  logic       pc_we, ir_we, iord, mem_rd, mem_wr, reg_dst, mem_to_reg, reg_we, retire;
  logic [1:0] alu_src_a, alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic       waiting;
  logic       timeout;

  // Ready on the final allowed cycle still wins, since the ready branch is checked first.
  assign timeout = (MAX_WAIT != 0) && (wait_q == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    mem_err_d  = mem_err_q;
    waiting    = 1'b0;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_we     = 1'b0;
    retire     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    pc_src     = 2'b00;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d   = S_TRAP;
          mem_err_d = 1'b1;
        end else begin
          waiting = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (bus.op)
          OP_LW, OP_SW:            state_d = S_MEM_ADDR;
          OP_RTYPE:                state_d = (bus.func == 6'b000000 || bus.func == 6'b000010 ||
                                              bus.func == 6'b000011) ? S_SH_EX : S_R_EX;
          OP_BEQ, OP_BNE:          state_d = S_BR;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_I_EX;
          OP_J:                    state_d = S_JMP;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = (bus.op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout) begin
          state_d   = S_TRAP;
          mem_err_d = 1'b1;
        end else begin
          waiting = 1'b1;
        end
      end
      S_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d   = S_TRAP;
          mem_err_d = 1'b1;
        end else begin
          waiting = 1'b1;
        end
      end
      S_R_EX: begin
        alu_src_a = 2'b01;
        alu_op    = 3'b010;
        state_d   = S_R_WB;
      end
      S_SH_EX: begin
        alu_src_a = 2'b10;
        alu_op    = 3'b010;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_I_EX: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = (bus.op == OP_ANDI) ? 3'b100 : (bus.op == OP_ORI) ? 3'b101 : 3'b000;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BR: begin
        alu_src_a = 2'b01;
        alu_op    = 3'b001;
        pc_src    = 2'b01;
        pc_we     = (bus.op == OP_BEQ) ? bus.zero : ~bus.zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JMP: begin
        pc_src  = 2'b10;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    if (state_d != state_q) wait_d = '0;
    else if (waiting)       wait_d = wait_q + 1'b1;
    else                    wait_d = wait_q;
  end

  assign bus.pc_we      = pc_we;
  assign bus.ir_we      = ir_we;
  assign bus.iord       = iord;
  assign bus.mem_rd     = mem_rd;
  assign bus.mem_wr     = mem_wr;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_we     = reg_we;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.pc_src     = pc_src;
  assign bus.retire     = retire;
  assign bus.state      = state_q;
  assign bus.illegal    = illegal_q;
  assign bus.mem_err    = mem_err_q;

endmodule
